bus_select_encoder: RTL and testbench

- Parametrised, registered one-hot-to-binary encoder that drives the bus multiplexer select from the datapath's N_SRC source-enable lines (general registers plus special/IO sources).
- Generalises the fixed 32-to-5 bus encoder:
  - configurable source count;
  - strict one-hot or lowest-index-priority mode;
  - explicit valid flag;
  - multi-hot error detection with a saturating error counter and a sticky flag cleared by acknowledge.
- Sits between the control unit's source-enable outputs and the bus mux select input.

---
 rtl/bus_select_encoder.sv | 97 +++++++++
 tb/tb_bus_select_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_select_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bus_select_encoder
// Purpose  : Registered one-hot to binary bus-select encoder with multi-hot
//            error detection.
// Revision : 1.0
// ============================================================================
module bus_select_encoder #(
    parameter int N_SRC         = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int CNT_W         = 8,
    localparam int SEL_W        = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [N_SRC-1:0] src_req,
    input  logic             err_ack,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             multi_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    localparam logic             c_PRIO    = (PRIORITY_MODE != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic             w_any;
    logic             w_multi;
    logic [SEL_W-1:0] w_low;

    logic [SEL_W-1:0] r_sel;
    logic             r_sel_valid;
    logic             r_multi_err;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_count;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign w_any   = |src_req;
    assign w_multi = |(src_req & (src_req - N_SRC'(1)));

    always_comb begin
        w_low = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                w_low = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_sel        <= '0;
            r_sel_valid  <= 1'b0;
            r_multi_err  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (enable) begin
                r_multi_err <= w_multi;
                if (w_multi) begin
                    r_sel_valid <= c_PRIO;
                    if (c_PRIO) begin
                        r_sel <= w_low;
                    end
                end else if (w_any) begin
                    r_sel       <= w_low;
                    r_sel_valid <= 1'b1;
                end else begin
                    r_sel_valid <= 1'b0;
                end
            end

            // A fresh error outranks an acknowledge of older ones.
            if (enable && w_multi) begin
                r_err_sticky <= 1'b1;
                if (err_ack) begin
                    r_err_count <= CNT_W'(1);
                end else if (r_err_count != c_CNT_MAX) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end else if (err_ack) begin
                r_err_sticky <= 1'b0;
                r_err_count  <= '0;
            end
        end
    end

    assign sel        = r_sel;
    assign sel_valid  = r_sel_valid;
    assign multi_err  = r_multi_err;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_select_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_select_encoder
// Purpose  : Directed self-checking bench for bus_select_encoder (strict,
//            priority and narrow-counter variants driven in parallel).
// Revision : 1.0
// ============================================================================
module tb_bus_select_encoder;

    logic        clk = 1'b0;
    logic        clear;
    logic        enable;
    logic [31:0] src_req;
    logic        err_ack;

    logic [4:0] s_sel, p_sel, c_sel;
    logic       s_valid, p_valid, c_valid;
    logic       s_multi, p_multi, c_multi;
    logic       s_sticky, p_sticky, c_sticky;
    logic [7:0] s_count, p_count;
    logic [2:0] c_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_select_encoder #(.N_SRC(32), .PRIORITY_MODE(0), .CNT_W(8)) u_strict (
        .clk(clk), .clear(clear), .enable(enable), .src_req(src_req), .err_ack(err_ack),
        .sel(s_sel), .sel_valid(s_valid), .multi_err(s_multi),
        .err_sticky(s_sticky), .err_count(s_count));

    bus_select_encoder #(.N_SRC(32), .PRIORITY_MODE(1), .CNT_W(8)) u_prio (
        .clk(clk), .clear(clear), .enable(enable), .src_req(src_req), .err_ack(err_ack),
        .sel(p_sel), .sel_valid(p_valid), .multi_err(p_multi),
        .err_sticky(p_sticky), .err_count(p_count));

    bus_select_encoder #(.N_SRC(32), .PRIORITY_MODE(0), .CNT_W(3)) u_sat (
        .clk(clk), .clear(clear), .enable(enable), .src_req(src_req), .err_ack(err_ack),
        .sel(c_sel), .sel_valid(c_valid), .multi_err(c_multi),
        .err_sticky(c_sticky), .err_count(c_count));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic clr, input logic en, input logic [31:0] req, input logic ack);
        clear   = clr;
        enable  = en;
        src_req = req;
        err_ack = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b1; enable = 1'b0; src_req = '0; err_ack = 1'b0;

        // reset
        step(1, 0, 32'h0, 0);
        step(1, 1, 32'hFFFF_FFFF, 1);
        chk("rst_sel",    s_sel,    0);
        chk("rst_valid",  s_valid,  0);
        chk("rst_multi",  s_multi,  0);
        chk("rst_sticky", s_sticky, 0);
        chk("rst_count",  s_count,  0);
        chk("rst_psel",   p_sel,    0);
        chk("rst_ccount", c_count,  0);

        // one-hot sweep
        for (int k = 0; k < 32; k++) begin
            step(0, 1, 32'h1 << k, 0);
            chk($sformatf("sweep_sel_%0d", k), s_sel, k);
            chk($sformatf("sweep_valid_%0d", k), s_valid, 1);
            chk($sformatf("sweep_multi_%0d", k), s_multi, 0);
            chk($sformatf("sweep_count_%0d", k), s_count, 0);
            chk($sformatf("sweep_psel_%0d", k), p_sel, k);
        end

        // idle hold
        step(0, 1, 32'h0001_0000, 0);
        chk("idle_sel16", s_sel, 16);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h0, 0);
            chk("idle_sel", s_sel, 16);
            chk("idle_valid", s_valid, 0);
        end
        step(0, 0, 32'h4, 0);
        chk("dis_sel", s_sel, 16);
        chk("dis_valid", s_valid, 0);

        // strict multi-hot vs priority
        step(0, 1, 32'h8, 0);
        chk("pre_sel3", s_sel, 3);
        step(0, 1, 32'h90, 0);
        chk("strict_sel",    s_sel,    3);
        chk("strict_valid",  s_valid,  0);
        chk("strict_multi",  s_multi,  1);
        chk("strict_sticky", s_sticky, 1);
        chk("strict_count",  s_count,  1);
        chk("prio90_sel",    p_sel,    4);
        chk("prio90_valid",  p_valid,  1);
        step(0, 1, 32'h8, 0);
        chk("recov_sel",    s_sel,    3);
        chk("recov_valid",  s_valid,  1);
        chk("recov_multi",  s_multi,  0);
        chk("recov_sticky", s_sticky, 1);

        // ack while disabled is still honoured
        step(0, 0, 32'h0, 1);
        chk("ack_dis_count",  s_count,  0);
        chk("ack_dis_sticky", s_sticky, 0);
        chk("ack_dis_valid",  s_valid,  1);

        // priority mode
        step(0, 1, 32'h00A0_0400, 0);
        chk("prio_sel",    p_sel,   10);
        chk("prio_valid",  p_valid, 1);
        chk("prio_multi",  p_multi, 1);
        chk("prio_count",  p_count, 1);
        chk("prio_ssel",   s_sel,   3);
        chk("prio_svalid", s_valid, 0);

        // saturation on the 3-bit counter
        step(0, 1, 32'h0, 1);
        chk("ack_ccount", c_count, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 32'h3, 0);
        chk("sat_ccount",  c_count,  7);
        chk("sat_csticky", c_sticky, 1);
        chk("sat_scount",  s_count,  9);
        chk("sat_psel",    p_sel,    0);
        step(0, 1, 32'h0, 1);
        chk("ack_c0",      c_count,  0);
        chk("ack_cst0",    c_sticky, 0);
        chk("ack_multi0",  c_multi,  0);
        step(0, 1, 32'h3, 1);
        chk("ackmh_ccount",  c_count,  1);
        chk("ackmh_csticky", c_sticky, 1);
        chk("ackmh_scount",  s_count,  1);
        chk("ackmh_multi",   c_multi,  1);

        // build up sel=21, count=5, then clear mid-operation
        for (int i = 0; i < 4; i++) step(0, 1, 32'h3, 0);
        step(0, 1, 32'h0020_0000, 0);
        chk("pre_clr_sel",   s_sel,   21);
        chk("pre_clr_count", c_count, 5);
        step(0, 0, 32'h3, 0);
        chk("hold_count", c_count, 5);
        chk("hold_multi", c_multi, 0);
        chk("hold_sel",   s_sel,   21);
        step(1, 1, 32'h2, 1);
        chk("clr_sel",    s_sel,    0);
        chk("clr_valid",  s_valid,  0);
        chk("clr_multi",  s_multi,  0);
        chk("clr_sticky", s_sticky, 0);
        chk("clr_count",  c_count,  0);
        step(0, 1, 32'h2, 0);
        chk("post_clr_sel",   s_sel,   1);
        chk("post_clr_valid", s_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
